// File: rtl/hazard_controller.sv
// Purpose: load-use / taken-branch / MDU-dependency stall and flush sequencer with saturating perf counters.
// Latency: all control outputs are combinational in the same cycle; FSM, watchdog and counters update on the next edge.
// Backpressure: a stall holds PC and IF/ID and bubbles ID/EX; a taken branch overrides any stall and flushes instead.
module hazard_controller #(
    parameter int MDU_MAX_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_is_mdu,
    input  logic             id_reads_hilo,
    input  logic             ex_branch_taken,
    input  logic             mdu_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    // Busy counter only needs to reach MDU_MAX_CYCLES-1.
    localparam int BUSY_W = (MDU_MAX_CYCLES > 1) ? $clog2(MDU_MAX_CYCLES) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MDU_MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mdu_hazard;
    logic stall;

    // Hazard detection and pipeline control; a taken branch wins over every stall.
    always_comb begin
        load_use     = 1'b0;
        mdu_hazard   = 1'b0;
        stall        = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mdu_start    = 1'b0;

        // Register 0 is hard-wired, so a load targeting it never creates a hazard.
        load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   ((id_uses_rs && (id_rs == id_ex_rd)) ||
                    (id_uses_rt && (id_rt == id_ex_rd)));
        // On the mdu_done cycle HI/LO is written, so a dependent instruction may issue.
        mdu_hazard = (state_q == MDU_BUSY) && (id_reads_hilo || id_is_mdu) && !mdu_done;
        stall      = (load_use || mdu_hazard) && !ex_branch_taken;

        pc_en        = !stall;
        if_id_en     = !stall;
        if_id_flush  = ex_branch_taken;
        id_ex_bubble = stall || ex_branch_taken;
        mdu_start    = id_is_mdu && !stall && !ex_branch_taken;
    end

    // MDU tracking FSM with busy watchdog; branches never disturb an issued MDU op.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                // mdu_done while idle has nothing to complete and is ignored.
                if (mdu_start) begin
                    state_d = MDU_BUSY;
                    busy_d  = '0;
                end
            end
            MDU_BUSY: begin
                if (mdu_done && mdu_start) begin
                    busy_d = '0;
                end else if (mdu_done) begin
                    state_d = RUN;
                end else if (busy_q == BUSY_LAST) begin
                    state_d   = RUN;
                    timeout_d = 1'b1;
                end else begin
                    busy_d = busy_q + BUSY_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                busy_d  = '0;
            end
        endcase
    end

    // Saturating performance counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_branch_taken && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, watchdog and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            busy_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mdu_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It works alongside the forwarding unit. Forwarding covers ALU-to-ALU dependencies; this block handles the cases forwarding cannot:
- load-use hazards;
- taken-branch redirects resolved in EX;
- dependencies on the multi-cycle multiply/divide unit (MDU).

It drives the PC and IF/ID enables, the ID/EX bubble insert and the flush lines. It also keeps saturating performance counters.

## Interface

Parameters:
- MDU_MAX_CYCLES, 64: watchdog limit on MDU busy cycles.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs / rt.
- id_ex_rd  in  5  destination register of the instruction in ID/EX.
- id_ex_mem_read  in  1  the ID/EX instruction is a load.
- id_is_mdu  in  1  the ID instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  the ID instruction is mfhi/mflo.
- ex_branch_taken  in  1  the branch/jump in EX redirects the PC this cycle.
- mdu_done  in  1  one-cycle pulse: the MDU result is written to HI/LO.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_bubble  out  1  load a NOP into ID/EX instead of the ID instruction.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_timeout  out  1  sticky watchdog error flag.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation

FSM states:
- RUN: no MDU operation outstanding.
- MDU_BUSY: an MDU operation is outstanding.

Outputs are combinational from the current state and inputs. The state, busy counter, mdu_timeout flag and performance counters are registered.

Hazard terms:
- load_use = id_ex_mem_read and id_ex_rd != 0 and ((id_uses_rs and id_rs == id_ex_rd) or (id_uses_rt and id_rt == id_ex_rd)).
- mdu_hazard = state MDU_BUSY and (id_reads_hilo or id_is_mdu) and not mdu_done.
- stall = (load_use or mdu_hazard) and not ex_branch_taken.

Output equations:
- pc_en = not stall.
- if_id_en = not stall.
- if_id_flush = ex_branch_taken.
- id_ex_bubble = stall or ex_branch_taken.
- mdu_start = id_is_mdu and not stall and not ex_branch_taken.

Transitions:
- RUN -> MDU_BUSY when mdu_start is asserted. The busy counter clears.
- MDU_BUSY -> RUN on mdu_done.
- MDU_BUSY -> RUN when the busy counter reaches MDU_MAX_CYCLES-1 without mdu_done. mdu_timeout sets and stays set until reset.
- MDU_BUSY stays MDU_BUSY when mdu_done and mdu_start occur in the same cycle (back-to-back MDU operation). The busy counter clears.

Priority and boundary rules:
- A taken branch outranks every stall. The ID instruction is wrong-path, so it is flushed, never stalled and never started.
- The FSM state is unaffected by ex_branch_taken. An MDU operation already issued is past EX and completes normally.
- Register 0 never produces a load-use hazard.
- mdu_done in RUN is ignored.

Counters:
- stall_cycles increments on every cycle with stall = 1.
- flush_count increments on every cycle with ex_branch_taken = 1.
- Both hold at all-ones and never wrap.

## Timing

- Reset (async assert, sync release):
  - state = RUN, busy counter = 0, mdu_timeout = 0, stall_cycles = 0, flush_count = 0.
  - With idle inputs the outputs are pc_en = 1, if_id_en = 1, if_id_flush = 0, id_ex_bubble = 0, mdu_start = 0.
- Reset asserted mid-MDU operation returns the FSM to RUN immediately. The MDU is reset by the same rst_n.
- Load-use costs exactly 1 stall cycle:
  - Cycle N: stall = 1, the bubble enters ID/EX.
  - Cycle N+1: the load is in EX/MEM, load_use = 0, the dependent instruction issues and the forwarding unit supplies the value from MEM/WB.
- Branch flush is a zero-latency combinational response in the same cycle ex_branch_taken is high.
- mdu_start is high for exactly the one cycle the MDU instruction leaves ID. The FSM is MDU_BUSY from the next cycle.
- A dependent mfhi/mflo stalls until the mdu_done cycle. It issues in that cycle, and the FSM is RUN in the next cycle.
- Watchdog: after MDU_MAX_CYCLES busy cycles without mdu_done, the FSM is RUN and mdu_timeout = 1 in the following cycle.

## Test plan

- Load-use: id_ex_mem_read = 1, id_ex_rd = 5, id_rs = 5, id_uses_rs = 1 -> exactly 1 cycle of pc_en = 0 and id_ex_bubble = 1; stall_cycles = 1. Repeat with id_ex_rd = 0 -> no stall.
- Branch with hazard: load_use true and ex_branch_taken = 1 in the same cycle -> pc_en = 1, if_id_flush = 1, id_ex_bubble = 1; stall_cycles unchanged; flush_count = 1.
- MDU dependency: id_is_mdu = 1 -> mdu_start pulses once; the next instruction (id_reads_hilo = 1) stalls; mdu_done after 10 cycles -> stall_cycles = 10 and the FSM returns to RUN.
- Back-to-back MDU: a second id_is_mdu arrives on the mdu_done cycle -> mdu_start = 1 in that cycle and the FSM stays MDU_BUSY.
- Watchdog: MDU_MAX_CYCLES = 8 and mdu_done never pulses -> mdu_timeout = 1 after 8 busy cycles and the FSM is RUN; the flag stays set until rst_n is asserted.
- Reset and saturation: assert rst_n low mid MDU_BUSY -> all outputs return to their reset values asynchronously. With CNT_W = 4, apply 20 stall cycles -> stall_cycles = 15.
